axi_wr_master: RTL and testbench
================================

// Module: axi_wr_master
// PURPOSE
//  AXI4 write master between the DDR3 write-side burst controller and the MIG AXI slave port, all on ui_clk.
//  Accepts one burst request (addr, len), then issues one INCR burst: AW, then W beats from the write FIFO, then B.
//  Pulses wr_burst_finish when the B response is received.
//  The burst controller advances its write address on that pulse.
// PARAMETERS
//  DATA_W     64    AXI wdata width; FIFO word width
//  ADDR_W     32    AXI awaddr width
//  ID_W       4     AXI awid width; awid is driven constant 0
//  MAX_LEN    256   largest accepted burst, in beats (AXI4 INCR limit)
//  TIMEOUT_CYC 4096 watchdog limit in cycles; used only when AXI_WR_TIMEOUT_EN is defined
// PORTS
//  ui_clk           in   1       system/AXI clock
//  ui_rst           in   1       reset, asynchronous, active-high
//  wr_burst_req     in   1       burst request; sampled only while wr_ready=1
//  wr_burst_addr    in   ADDR_W  byte address of the burst
//  wr_burst_len     in   10      burst length in beats, 1..MAX_LEN
//  wr_ready         out  1       master idle, can accept a request
//  wr_fifo_re       out  1       write-FIFO read enable (FIFO is first-word-fall-through)
//  wr_fifo_data     in   DATA_W  write-FIFO head word
//  wr_burst_finish  out  1       1-cycle pulse when the burst completes
//  wr_resp_err      out  1       sticky flag: some burst received bresp!=OKAY
//  m_axi_aw*        out  awid,awaddr,awlen[7:0],awsize[2:0],awburst[1:0],awlock,awcache[3:0],awprot[2:0],awqos[3:0],awvalid
//  m_axi_awready    in   1
//  m_axi_w*         out  wdata,wstrb,wlast,wvalid
//  m_axi_wready     in   1
//  m_axi_b*         in   bid,bresp[1:0],bvalid;  m_axi_bready out 1
//  wr_timeout       out  1       sticky watchdog flag (port present only with AXI_WR_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: FSM=IDLE; wr_ready, wr_fifo_re, wr_burst_finish, awvalid, wvalid, wlast, bready, wr_resp_err, wr_timeout = 0.
//    wr_ready rises 1 cycle after ui_rst deasserts. A reset mid-burst abandons the burst; no finish pulse.
//  - FSM IDLE->AW->W->B->IDLE.
//  - IDLE: wr_ready=1. On wr_burst_req=1 with len in 1..MAX_LEN:
//      latch awaddr<=addr and awlen<=len-1 (8 bits); wr_ready<=0; next state AW.
//    len=0 or len>MAX_LEN: the request is dropped and the FSM stays IDLE.
//  - AW: awvalid=1, held with awaddr/awlen stable until awready. On awready, next state W; beat_cnt<=0.
//  - W: wvalid=1; wdata=wr_fifo_data (combinational); wstrb all-ones; wr_fifo_re = wvalid & wready.
//    beat_cnt increments on each handshake; wlast = (beat_cnt==awlen).
//    The handshake with wlast moves the FSM to B.
//    The FIFO is guaranteed to hold >= len words when the request is issued, so wvalid is never gated by FIFO empty.
//  - B: bready=1. On bvalid, wr_burst_finish=1 for exactly 1 cycle.
//    Also in that cycle, if bresp!=2'b00, set wr_resp_err (sticky until reset).
//    Next state IDLE; wr_ready=1 in the following cycle.
//  - Fixed fields: awsize=log2(DATA_W/8) (3'b011 for 64-bit), awburst=2'b01 (INCR), awcache=4'b0011, others 0.
//  - No 4 KB boundary splitting; the requester guarantees bursts do not cross 4 KB.
//  - Minimum burst-to-burst spacing is 1 IDLE cycle.
// CONFIGURATION
//  AXI_WR_TIMEOUT_EN defined:
//    - A 16-bit watchdog counts cycles in AW/W/B without the awaiting handshake; it clears on each handshake.
//    - On reaching TIMEOUT_CYC: set wr_timeout (sticky), drop awvalid/wvalid/bready, return to IDLE, no finish pulse.
//  Undefined: no watchdog and no wr_timeout port; the FSM waits indefinitely.
// STRUCTURE
//  - Package axi_ddr3_pkg: FSM state encoding; AXI_BURST_INCR=2'b01; AXI_RESP_OKAY=2'b00; AXI_CACHE_DEF=4'b0011.
//  - No sub-module: the beat counter and watchdog are inline.
// TESTING
//  1 Reset: hold ui_rst 5 cycles -> all outputs 0; wr_ready=1 one cycle after release.
//  2 addr=0x1000, len=128, slave always ready -> awlen=127; 128 W beats with data = FIFO words in order;
//    wlast on beat 128 only; 128 wr_fifo_re; 1 finish pulse.
//  3 len=1, awready delayed 7 cycles, random wready backpressure ->
//    awaddr/awlen stable while waiting; single beat with wlast=1; wr_fifo_re only on the handshake.
//  4 bresp=2'b10 on a len=16 burst -> finish still pulses; wr_resp_err=1 and stays 1 through the next OKAY burst.
//  5 len=0 and len=300 requests -> no awvalid; wr_ready stays 1.
//    Reset asserted at beat 40 of 128 -> immediate IDLE, no finish.
//  6 AXI_WR_TIMEOUT_EN, TIMEOUT_CYC=64, bvalid never asserted -> wr_timeout=1 after 64 cycles in B; FSM returns to IDLE.

Source files
------------

// File: rtl/axi_ddr3_pkg.sv
// Package: axi_ddr3_pkg
// Shared types and AXI constants for the DDR3 AXI write path.
//   wr_state_e     : write-master FSM state encoding
//   AXI_BURST_INCR : awburst code for incrementing bursts
//   AXI_RESP_OKAY  : bresp code for a clean write
//   AXI_CACHE_DEF  : awcache value (bufferable, modifiable)
//   axi_size()     : awsize code for a given data width
package axi_ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

  // Bytes per beat as a log2 code, e.g. 64-bit -> 3'b011.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_wr_master.sv
// Module: axi_wr_master
// AXI4 write master between the DDR3 write burst controller and the MIG
// AXI slave port. Takes one (addr, len) request, issues a single INCR burst
// (AW, len W beats pulled from a FWFT write FIFO, then B) and pulses
// wr_burst_finish on the B handshake.
// Ports:
//   ui_clk, ui_rst            clock, async active-high reset
//   wr_burst_req/addr/len     burst request (accepted only while wr_ready)
//   wr_ready                  idle, can take a request
//   wr_fifo_re, wr_fifo_data  FIFO pop strobe and head word
//   wr_burst_finish           1-cycle pulse on B handshake
//   wr_resp_err               sticky: a burst got bresp != OKAY
//   m_axi_aw*/w*/b*           AXI4 write channels
//   wr_timeout                sticky watchdog flag (AXI_WR_TIMEOUT_EN only)
// Build option: define AXI_WR_TIMEOUT_EN to add the watchdog and wr_timeout.
module axi_wr_master
  import axi_ddr3_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_LEN = 256
`ifdef AXI_WR_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic                ui_clk,
  input  logic                ui_rst,
  input  logic                wr_burst_req,
  input  logic [ADDR_W-1:0]   wr_burst_addr,
  input  logic [9:0]          wr_burst_len,
  output logic                wr_ready,
  output logic                wr_fifo_re,
  input  logic [DATA_W-1:0]   wr_fifo_data,
  output logic                wr_burst_finish,
  output logic                wr_resp_err,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
`ifdef AXI_WR_TIMEOUT_EN
  , output logic              wr_timeout
`endif
);

  wr_state_e         state, state_n;
  logic [ADDR_W-1:0] awaddr_q;
  logic [7:0]        awlen_q;
  logic [7:0]        beat_cnt;
  logic              req_ok;
  logic              hs;
  logic              to_hit;

  // Only one outstanding write, so the response ID carries no information.
  logic unused_bid;
  assign unused_bid = &{1'b0, m_axi_bid};

  assign req_ok = wr_ready && wr_burst_req && (wr_burst_len != 10'd0) &&
                  (wr_burst_len <= 10'(MAX_LEN));

  // Handshake the current state is waiting for.
  assign hs = ((state == ST_AW) && m_axi_awready) ||
              ((state == ST_W)  && m_axi_wready)  ||
              ((state == ST_B)  && m_axi_bvalid);

`ifdef AXI_WR_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign to_hit = (state != ST_IDLE) && !hs && (wd_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      wd_cnt     <= '0;
      wr_timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE || hs || to_hit) wd_cnt <= '0;
      else                                  wd_cnt <= wd_cnt + 16'd1;
      if (to_hit) wr_timeout <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state       <= ST_IDLE;
      wr_ready    <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      beat_cnt    <= '0;
      wr_resp_err <= 1'b0;
    end else begin
      state <= state_n;
      // Registered so it stays low during reset and rises one cycle later.
      wr_ready <= (state_n == ST_IDLE);
      if (req_ok) begin
        awaddr_q <= wr_burst_addr;
        awlen_q  <= 8'(wr_burst_len - 10'd1);
      end
      if (state == ST_AW && m_axi_awready)     beat_cnt <= '0;
      else if (m_axi_wvalid && m_axi_wready)   beat_cnt <= beat_cnt + 8'd1;
      if (state == ST_B && m_axi_bvalid && m_axi_bresp != AXI_RESP_OKAY)
        wr_resp_err <= 1'b1;
    end
  end

  always_comb begin
    state_n         = state;
    m_axi_awvalid   = 1'b0;
    m_axi_wvalid    = 1'b0;
    m_axi_wlast     = 1'b0;
    m_axi_bready    = 1'b0;
    wr_burst_finish = 1'b0;
    case (state)
      ST_IDLE: if (req_ok) state_n = ST_AW;
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_n = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = (beat_cnt == awlen_q);
        if (m_axi_wready && m_axi_wlast) state_n = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          wr_burst_finish = 1'b1;
          state_n         = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Watchdog abandons the burst; only fires in cycles with no handshake.
    if (to_hit) state_n = ST_IDLE;
    wr_fifo_re = m_axi_wvalid && m_axi_wready;
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = axi_size(DATA_W);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEF;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_wdata   = wr_fifo_data;
  assign m_axi_wstrb   = '1;

endmodule

// File: tb/tb_axi_wr_master.sv
// Testbench: tb_axi_wr_master
// Directed tests for axi_wr_master: reset, long burst, backpressure,
// error response, illegal lengths, mid-burst reset and (with
// AXI_WR_TIMEOUT_EN) the watchdog. The FIFO is a FWFT model whose head
// word is a function of its read pointer.
module tb_axi_wr_master;

  logic        ui_clk = 1'b0;
  logic        ui_rst = 1'b1;
  logic        wr_burst_req = 1'b0;
  logic [31:0] wr_burst_addr = '0;
  logic [9:0]  wr_burst_len = '0;
  logic        wr_ready, wr_fifo_re, wr_burst_finish, wr_resp_err;
  logic [63:0] wr_fifo_data;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [3:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
`ifdef AXI_WR_TIMEOUT_EN
  logic        wr_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int fin_cnt = 0;
  int re_cnt = 0;
  logic [31:0] rd_ptr = '0;

  always #5 ui_clk = ~ui_clk;

  axi_wr_master #(
    .DATA_W(64), .ADDR_W(32), .ID_W(4), .MAX_LEN(256)
`ifdef AXI_WR_TIMEOUT_EN
    , .TIMEOUT_CYC(64)
`endif
  ) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
    .wr_burst_len(wr_burst_len), .wr_ready(wr_ready),
    .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
    .wr_burst_finish(wr_burst_finish), .wr_resp_err(wr_resp_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
`ifdef AXI_WR_TIMEOUT_EN
    , .wr_timeout(wr_timeout)
`endif
  );

  function automatic logic [63:0] word(input logic [31:0] i);
    return {~i, i};
  endfunction

  // FWFT FIFO model: head word follows the read pointer.
  assign wr_fifo_data = word(rd_ptr);
  always @(posedge ui_clk) if (wr_fifo_re) rd_ptr <= rd_ptr + 32'd1;

  // Pulse counters, sampled mid-cycle.
  always begin
    @(negedge ui_clk);
    #2;
    if (wr_burst_finish) fin_cnt++;
    if (wr_fifo_re) re_cnt++;
  end

  // Drives one burst and reports what it saw; the test tasks judge it.
  task automatic do_burst(input logic [31:0] addr, input int len, input int aw_delay,
                          input bit bp, input logic [1:0] bresp_v, input int stop_beat,
                          input bit skip_b,
                          output int beats, output int last_err, output int data_err,
                          output int re_err, output int aw_unstable, output int aw_wait,
                          output logic [7:0] awlen_seen, output logic [31:0] addr_seen,
                          output int b_ok);
    int n;
    bit done, first;
    beats = 0; last_err = 0; data_err = 0; re_err = 0; aw_unstable = 0;
    aw_wait = 0; awlen_seen = '0; addr_seen = '0; b_ok = 0;
    @(negedge ui_clk);
    n = 0;
    while (!wr_ready && n < 50) begin @(negedge ui_clk); n++; end
    wr_burst_req = 1'b1; wr_burst_addr = addr; wr_burst_len = 10'(len);
    @(negedge ui_clk);
    wr_burst_req = 1'b0;
    n = 0; done = 0; first = 1;
    while (!done && n < 100) begin
      m_axi_awready = (n >= aw_delay);
      #1;
      if (m_axi_awvalid) begin
        if (first) begin addr_seen = m_axi_awaddr; awlen_seen = m_axi_awlen; first = 0; end
        else if (m_axi_awaddr !== addr_seen || m_axi_awlen !== awlen_seen) aw_unstable++;
        if (m_axi_awready) done = 1; else aw_wait++;
      end
      @(negedge ui_clk); n++;
    end
    m_axi_awready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL aw_handshake: no AW handshake, required within 100 cycles"); return; end
    n = 0; done = 0;
    while (!done && n < 2000) begin
      m_axi_wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        beats++;
        if (m_axi_wlast !== (beats == len)) last_err++;
        if (m_axi_wdata !== word(32'(exp_idx))) data_err++;
        if (wr_fifo_re !== 1'b1) re_err++;
        exp_idx++;
        if (beats == len || beats == stop_beat) done = 1;
      end else if (wr_fifo_re !== 1'b0) re_err++;
      @(negedge ui_clk); n++;
    end
    m_axi_wready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL w_beats: got %0d beats, required %0d", beats, len); return; end
    if (stop_beat != 0 || skip_b) return;
    n = 0; done = 0;
    while (!done && n < 50) begin
      m_axi_bvalid = 1'b1; m_axi_bresp = bresp_v;
      #1;
      if (m_axi_bready) begin done = 1; if (wr_burst_finish === 1'b1) b_ok = 1; end
      @(negedge ui_clk); n++;
    end
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  task automatic test_reset();
    ui_rst = 1'b1;
    repeat (5) @(negedge ui_clk);
    #1;
    checks++;
    if ({wr_ready, wr_fifo_re, wr_burst_finish, m_axi_awvalid, m_axi_wvalid,
         m_axi_wlast, m_axi_bready, wr_resp_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {wr_ready, wr_fifo_re, wr_burst_finish, m_axi_awvalid, m_axi_wvalid,
                m_axi_wlast, m_axi_bready, wr_resp_err});
    end
`ifdef AXI_WR_TIMEOUT_EN
    checks++;
    if (wr_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", wr_timeout); end
`endif
    @(negedge ui_clk);
    ui_rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL ready_release: got %b, required 0", wr_ready); end
    @(negedge ui_clk);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after: got %b, required 1", wr_ready); end
  endtask

  task automatic test_long_burst();
    int beats, le, de, re, un, aw, bok, f0, r0;
    logic [7:0] al; logic [31:0] ad;
    f0 = fin_cnt; r0 = re_cnt;
    do_burst(32'h1000, 128, 0, 0, 2'b00, 0, 0, beats, le, de, re, un, aw, al, ad, bok);
    @(negedge ui_clk);
    checks++; if (al !== 8'd127) begin errors++; $display("FAIL long_awlen: got %0d, required 127", al); end
    checks++; if (ad !== 32'h1000) begin errors++; $display("FAIL long_awaddr: got %h, required 00001000", ad); end
    checks++; if (beats !== 128) begin errors++; $display("FAIL long_beats: got %0d, required 128", beats); end
    checks++; if (le !== 0) begin errors++; $display("FAIL long_wlast: %0d bad beats, required 0", le); end
    checks++; if (de !== 0) begin errors++; $display("FAIL long_wdata: %0d bad beats, required 0", de); end
    checks++; if (re_cnt - r0 !== 128) begin errors++; $display("FAIL long_fifo_re: got %0d, required 128", re_cnt - r0); end
    checks++; if (fin_cnt - f0 !== 1 || bok !== 1) begin errors++; $display("FAIL long_finish: got %0d pulses (b_ok %0d), required 1", fin_cnt - f0, bok); end
    checks++;
    if ({m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb, m_axi_awid} !== {3'b011, 2'b01, 4'b0011, 8'hff, 4'h0}) begin
      errors++;
      $display("FAIL fixed_fields: got size %b burst %b cache %b strb %h id %h, required 011 01 0011 ff 0",
               m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb, m_axi_awid);
    end
  endtask

  task automatic test_backpressure();
    int beats, le, de, re, un, aw, bok, r0;
    logic [7:0] al; logic [31:0] ad;
    r0 = re_cnt;
    do_burst(32'h2040, 1, 7, 1, 2'b00, 0, 0, beats, le, de, re, un, aw, al, ad, bok);
    @(negedge ui_clk);
    checks++; if (aw !== 7) begin errors++; $display("FAIL bp_aw_wait: got %0d, required 7", aw); end
    checks++; if (un !== 0 || al !== 8'd0 || ad !== 32'h2040) begin errors++; $display("FAIL bp_aw_stable: unstable %0d awlen %0d addr %h, required 0 0 00002040", un, al, ad); end
    checks++; if (beats !== 1 || le !== 0 || de !== 0) begin errors++; $display("FAIL bp_beat: beats %0d wlast_err %0d data_err %0d, required 1 0 0", beats, le, de); end
    checks++; if (re !== 0 || re_cnt - r0 !== 1) begin errors++; $display("FAIL bp_fifo_re: misplaced %0d count %0d, required 0 1", re, re_cnt - r0); end
  endtask

  task automatic test_resp_err();
    int beats, le, de, re, un, aw, bok, f0;
    logic [7:0] al; logic [31:0] ad;
    checks++; if (wr_resp_err !== 1'b0) begin errors++; $display("FAIL err_before: got %b, required 0", wr_resp_err); end
    f0 = fin_cnt;
    do_burst(32'h3000, 16, 0, 0, 2'b10, 0, 0, beats, le, de, re, un, aw, al, ad, bok);
    @(negedge ui_clk);
    checks++; if (fin_cnt - f0 !== 1) begin errors++; $display("FAIL err_finish: got %0d pulses, required 1", fin_cnt - f0); end
    checks++; if (wr_resp_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b, required 1", wr_resp_err); end
    f0 = fin_cnt;
    do_burst(32'h3100, 4, 0, 0, 2'b00, 0, 0, beats, le, de, re, un, aw, al, ad, bok);
    @(negedge ui_clk);
    checks++; if (wr_resp_err !== 1'b1 || fin_cnt - f0 !== 1) begin errors++; $display("FAIL err_sticky: err %b pulses %0d, required 1 1", wr_resp_err, fin_cnt - f0); end
  endtask

  task automatic test_bad_len();
    int bad;
    int lens[2] = '{0, 300};
    foreach (lens[k]) begin
      bad = 0;
      @(negedge ui_clk);
      wr_burst_req = 1'b1; wr_burst_addr = 32'h4000; wr_burst_len = 10'(lens[k]);
      @(negedge ui_clk);
      wr_burst_req = 1'b0;
      repeat (3) begin
        #1;
        if (m_axi_awvalid !== 1'b0 || wr_ready !== 1'b1) bad++;
        @(negedge ui_clk);
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL bad_len_%0d: %0d cycles with awvalid or !wr_ready, required 0", lens[k], bad); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats, le, de, re, un, aw, bok, f0;
    logic [7:0] al; logic [31:0] ad;
    f0 = fin_cnt;
    do_burst(32'h5000, 128, 0, 0, 2'b00, 40, 0, beats, le, de, re, un, aw, al, ad, bok);
    ui_rst = 1'b1;
    #1;
    checks++;
    if ({m_axi_wvalid, wr_fifo_re, wr_ready, wr_burst_finish} !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs: got %b, required 0000", {m_axi_wvalid, wr_fifo_re, wr_ready, wr_burst_finish});
    end
    repeat (2) @(negedge ui_clk);
    ui_rst = 1'b0;
    repeat (3) @(negedge ui_clk);
    #1;
    checks++;
    if (fin_cnt - f0 !== 0 || wr_ready !== 1'b1 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || wr_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: pulses %0d ready %b awvalid %b wvalid %b err %b, required 0 1 0 0 0",
               fin_cnt - f0, wr_ready, m_axi_awvalid, m_axi_wvalid, wr_resp_err);
    end
  endtask

`ifdef AXI_WR_TIMEOUT_EN
  task automatic test_timeout();
    int beats, le, de, re, un, aw, bok, f0, n, bcyc;
    logic [7:0] al; logic [31:0] ad;
    f0 = fin_cnt;
    do_burst(32'h6000, 1, 0, 0, 2'b00, 0, 1, beats, le, de, re, un, aw, al, ad, bok);
    n = 0; bcyc = 0;
    while (!wr_timeout && n < 200) begin
      #1;
      if (m_axi_bready) bcyc++;
      @(negedge ui_clk); n++;
    end
    #1;
    checks++; if (wr_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b, required 1", wr_timeout); end
    checks++; if (bcyc !== 64) begin errors++; $display("FAIL timeout_cycles: got %0d cycles in B, required 64", bcyc); end
    checks++; if (m_axi_bready !== 1'b0 || wr_ready !== 1'b1 || fin_cnt - f0 !== 0) begin errors++; $display("FAIL timeout_idle: bready %b ready %b pulses %0d, required 0 1 0", m_axi_bready, wr_ready, fin_cnt - f0); end
  endtask
`endif

  initial begin
    test_reset();
    test_long_burst();
    test_backpressure();
    test_resp_err();
    test_bad_len();
    test_reset_mid_burst();
`ifdef AXI_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
